// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one synchronous sprite ROM between NUM_REQ sprite-draw requesters on
// vga_clk. At most one read is granted per cycle, round-robin from a rotating
// pointer. The returned ROM word is tagged with the requester ID through a
// ROM_LAT-deep {valid, id} pipeline that lines up with the ROM read latency.
//
// Optional feature macro: FIXED_PRIO0_EN
//   defined   -> requester 0 always wins when it requests; requesters
//                1..NUM_REQ-1 round-robin among themselves (ptr wraps to 1).
//   undefined -> pure round-robin over all requesters.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                        vga_clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]           rom_address,
    input  logic [DATA_W-1:0]           rom_q,
    output logic                        rd_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rd_id,
    output logic [DATA_W-1:0]           rd_data
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic              any_gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] addr_hold;
    logic [ROM_LAT-1:0] vld_pipe;
    logic [ID_W-1:0]   id_pipe [ROM_LAT];

    // Pick the winning requester: first set req bit searching upward from ptr.
    // NOTE: every variable written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin : arb_comb
        int start;
        int c;
        any_gnt = 1'b0;
        gnt_id  = '0;
        start   = 0;
        c       = 0;
        // Grants are suppressed while reset is held so nothing leaks to the ROM.
        if (reset_n && en) begin
`ifdef FIXED_PRIO0_EN
            if (req[0]) begin
                any_gnt = 1'b1;
                gnt_id  = '0;
            end else begin
                // ptr lives in 1..NUM_REQ-1 here; the reset value 0 means "start at 1".
                start = (ptr == '0) ? 1 : int'(ptr);
                for (int off = 0; off < NUM_REQ - 1; off++) begin
                    c = start + off;
                    if (c >= NUM_REQ) c = c - (NUM_REQ - 1);
                    if (!any_gnt && req[ID_W'(c)]) begin
                        any_gnt = 1'b1;
                        gnt_id  = ID_W'(c);
                    end
                end
            end
`else
            start = int'(ptr);
            for (int off = 0; off < NUM_REQ; off++) begin
                c = start + off;
                if (c >= NUM_REQ) c = c - NUM_REQ;
                if (!any_gnt && req[ID_W'(c)]) begin
                    any_gnt = 1'b1;
                    gnt_id  = ID_W'(c);
                end
            end
`endif
        end
    end

    // Expand the winning ID to the one-hot grant vector.
    always_comb begin
        gnt = '0;
        if (any_gnt) gnt[gnt_id] = 1'b1;
    end

    // Rotate the pointer past the requester just served; hold when idle.
    always_comb begin
        ptr_nxt = ptr;
        if (any_gnt) begin
`ifdef FIXED_PRIO0_EN
            // Requester 0 is outside the rotation, so its grants leave ptr alone.
            if (gnt_id != '0)
                ptr_nxt = (int'(gnt_id) == NUM_REQ - 1) ? ID_W'(1) : ID_W'(int'(gnt_id) + 1);
`else
            ptr_nxt = (int'(gnt_id) == NUM_REQ - 1) ? '0 : ID_W'(int'(gnt_id) + 1);
`endif
        end
    end

    // Select the granted requester's address slice.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Drive the granted address straight through; otherwise park on the last
    // granted address so the ROM address bus stays quiet between reads.
    assign rom_address = any_gnt ? sel_addr : addr_hold;

    // Pointer, address hold register and the {valid, id} return pipeline.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift works in one pass.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            addr_hold <= '0;
            vld_pipe  <= '0;
            // NOTE: the ID stages are reset too (not just valid) so rd_id reads 0
            // out of reset; the array is only ROM_LAT entries deep.
            for (int i = 0; i < ROM_LAT; i++) id_pipe[i] <= '0;
        end else begin
            ptr         <= ptr_nxt;
            if (any_gnt) addr_hold <= sel_addr;
            vld_pipe[0] <= any_gnt;
            id_pipe[0]  <= gnt_id;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // The last pipeline stage lines up with the ROM output word.
    assign rd_valid = vld_pipe[ROM_LAT-1];
    assign rd_id    = id_pipe[ROM_LAT-1];
    assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter. Two instances share clock, reset and
// request inputs: u_dut1 with a 1-cycle ROM, u_dut2 with a 2-cycle ROM. Each
// has its own behavioural synchronous ROM whose contents come from rom_fn.
module tb_sprite_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en      = 1'b0;
    logic [3:0]  req     = '0;
    logic [39:0] req_addr = '0;

    logic [3:0]  gnt1, gnt2;
    logic [9:0]  rom_addr1, rom_addr2;
    logic [7:0]  rom_q1 = '0, rom_q2 = '0, rom2_s1 = '0;
    logic        rd_valid1, rd_valid2;
    logic [1:0]  rd_id1, rd_id2;
    logic [7:0]  rd_data1, rd_data2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(8), .ROM_LAT(1)) u_dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
        .gnt(gnt1), .rom_address(rom_addr1), .rom_q(rom_q1),
        .rd_valid(rd_valid1), .rd_id(rd_id1), .rd_data(rd_data1)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(8), .ROM_LAT(2)) u_dut2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
        .gnt(gnt2), .rom_address(rom_addr2), .rom_q(rom_q2),
        .rd_valid(rd_valid2), .rd_id(rd_id2), .rd_data(rd_data2)
    );

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h2A};
    endfunction

    always @(posedge vga_clk) rom_q1 <= rom_fn(rom_addr1);
    always @(posedge vga_clk) begin
        rom2_s1 <= rom_fn(rom_addr2);
        rom_q2  <= rom2_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_addr(input int idx, input logic [9:0] a);
        req_addr[idx*10 +: 10] = a;
    endtask

    // Step tables for the en-toggle sequence with req=1010.
    int en_seq [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int gnt_seq[8] = '{2, 8, 2, 0, 0, 0, 8, 2};
    int rv1_seq[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int id1_seq[8] = '{3, 1, 3, 1, 0, 0, 0, 3};
    int rv2_seq[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int id2_seq[8] = '{2, 3, 1, 3, 1, 0, 0, 0};

`ifdef FIXED_PRIO0_EN
    int g0111[4] = '{1, 1, 1, 1};
`else
    int g0111[4] = '{2, 4, 1, 2};
`endif
    int g0110[4] = '{4, 2, 4, 2};

    initial begin
        // ---- Held in reset with everything requesting: grants forced off ----
        en  = 1'b1;
        req = 4'hF;
        @(negedge vga_clk);
        check("rst_gnt", 32'(gnt1), 32'h0);
        check("rst_rd_valid", 32'(rd_valid1), 32'h0);
        check("rst_rom_address", 32'(rom_addr1), 32'h0);
        check("rst_rd_id", 32'(rd_id1), 32'h0);

        // ---- Release with no requests: idle for 10 cycles ----
        next_cycle();
        reset_n = 1'b1;
        req     = 4'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge vga_clk);
            check($sformatf("idle_gnt[%0d]", k), 32'(gnt1), 32'h0);
            check($sformatf("idle_rd_valid[%0d]", k), 32'(rd_valid1 | rd_valid2), 32'h0);
            check($sformatf("idle_rom_address[%0d]", k), 32'(rom_addr1), 32'h0);
            next_cycle();
        end

        // ---- Single read from requester 0 ----
        req = 4'b0001;
        set_addr(0, 10'h155);
        @(negedge vga_clk);
        check("single_gnt", 32'(gnt1), 32'h1);
        check("single_rom_address", 32'(rom_addr1), 32'h155);
        next_cycle();
        req = 4'b0000;
        @(negedge vga_clk);
        check("single_gnt_after", 32'(gnt1), 32'h0);
        check("single_addr_hold", 32'(rom_addr1), 32'h155);
        check("single_rd_valid", 32'(rd_valid1), 32'h1);
        check("single_rd_id", 32'(rd_id1), 32'h0);
        check("single_rd_data", 32'(rd_data1), 32'(rom_fn(10'h155)));
        check("single_lat2_early", 32'(rd_valid2), 32'h0);
        next_cycle();
        @(negedge vga_clk);
        check("single_rd_valid_done", 32'(rd_valid1), 32'h0);
        check("single_lat2_valid", 32'(rd_valid2), 32'h1);
        check("single_lat2_data", 32'(rd_data2), 32'(rom_fn(10'h155)));

        // ---- Requester 3 alone (ptr was 1), wraps ptr back to 0 ----
        next_cycle();
        req = 4'b1000;
        set_addr(3, 10'h2C3);
        @(negedge vga_clk);
        check("wrap_gnt", 32'(gnt1), 32'h8);
        check("wrap_rom_address", 32'(rom_addr1), 32'h2C3);

        // ---- All four requesting for 8 cycles: strict rotation ----
        next_cycle();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 10'(10'h100 + i));
        for (int k = 0; k < 8; k++) begin
            @(negedge vga_clk);
            check($sformatf("rot_gnt[%0d]", k), 32'(gnt1), 32'(1 << (k % 4)));
            check($sformatf("rot_rom_address[%0d]", k), 32'(rom_addr1), 32'(10'h100 + (k % 4)));
            check($sformatf("rot_rd_valid[%0d]", k), 32'(rd_valid1), 32'h1);
            check($sformatf("rot_rd_id[%0d]", k), 32'(rd_id1), (k == 0) ? 32'd3 : 32'((k - 1) % 4));
            check($sformatf("rot_rd_data[%0d]", k), 32'(rd_data1),
                  32'(rom_fn((k == 0) ? 10'h2C3 : 10'(10'h100 + (k - 1) % 4))));
            if (k >= 2)
                check($sformatf("rot_lat2_id[%0d]", k), 32'(rd_id2), 32'((k - 2) % 4));
            next_cycle();
        end

        // ---- req=1010 with en low for 3 cycles mid-stream ----
        req = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            en = en_seq[k][0];
            @(negedge vga_clk);
            check($sformatf("en_gnt[%0d]", k), 32'(gnt1), 32'(gnt_seq[k]));
            check($sformatf("en_rd_valid[%0d]", k), 32'(rd_valid1), 32'(rv1_seq[k]));
            if (rv1_seq[k] == 1)
                check($sformatf("en_rd_id[%0d]", k), 32'(rd_id1), 32'(id1_seq[k]));
            check($sformatf("en_lat2_valid[%0d]", k), 32'(rd_valid2), 32'(rv2_seq[k]));
            if (rv2_seq[k] == 1)
                check($sformatf("en_lat2_id[%0d]", k), 32'(rd_id2), 32'(id2_seq[k]));
            next_cycle();
        end

        // ---- Grant to requester 2, reset asserted half a cycle later ----
        req = 4'b0100;
        set_addr(2, 10'h0AB);
        @(negedge vga_clk);
        check("rstmid_gnt", 32'(gnt1), 32'h4);
        reset_n = 1'b0;
        #1;
        check("rstmid_gnt_forced", 32'(gnt2), 32'h0);
        next_cycle();
        @(negedge vga_clk);
        check("rstmid_t1_valid1", 32'(rd_valid1), 32'h0);
        check("rstmid_t1_valid2", 32'(rd_valid2), 32'h0);
        next_cycle();
        @(negedge vga_clk);
        check("rstmid_t2_valid2", 32'(rd_valid2), 32'h0);
        next_cycle();
        reset_n = 1'b1;
        req     = 4'b1111;
        @(negedge vga_clk);
        check("rstmid_ptr0_gnt1", 32'(gnt1), 32'h1);
        check("rstmid_ptr0_gnt2", 32'(gnt2), 32'h1);
        next_cycle();
        req = 4'b0000;
        next_cycle();

        // ---- req=0111 for 4 cycles, then req=0110 for 4 cycles ----
        req = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            @(negedge vga_clk);
            check($sformatf("p0111_gnt[%0d]", k), 32'(gnt1), 32'(g0111[k]));
            next_cycle();
        end
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            @(negedge vga_clk);
            check($sformatf("p0110_gnt[%0d]", k), 32'(gnt1), 32'(g0110[k]));
            next_cycle();
        end

        req = 4'b0000;
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
